// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the command-stream manager and
// the register-mapped slave it fronts.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NONSEQ = 2'd2
  } htrans_t;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [1:0] {
    RUN,
    ERR2,
    REISSUE
  } master_state_t;

  // Slave register map
  localparam int ERR_STATUS_ADDRESS = 1;
  localparam int PAYLOAD_ADDRESS    = 2;
  localparam int DATA_SIZE_ADDRESS  = 4;

  // Field widths of the phase registers; the manager's ADDR_W/DATA_W track these
  localparam int XFER_ADDR_W = 3;
  localparam int XFER_DATA_W = 8;

  typedef struct packed {
    logic                   write;
    logic [XFER_ADDR_W-1:0] addr;
    logic [2:0]             size;
    logic [XFER_DATA_W-1:0] wdata;
    logic                   valid;
  } xfer_t;

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding pipelined AHB-Lite manager: command stream in, AHB
// transfers out, with wait-state handling and ERROR cancel/reissue.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = XFER_ADDR_W,
  parameter int DATA_W = XFER_DATA_W
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hsel_x,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  master_state_t     state_q, state_n;
  xfer_t             a_p0, a_p0_n;
  xfer_t             d_p1, d_p1_n;
  xfer_t             hold_q, hold_n;
  xfer_t             cmd_x;
  logic              cancel_q, cancel_n;
  logic              accept;
  logic              hsel_n;
  logic              rsp_valid_n, rsp_write_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_rdata_n;
  logic              unused_d_fields;

  assign cmd_ready = hready && (state_q == RUN) && hreset_n;
  assign accept    = cmd_valid && cmd_ready;

  // Address phase outputs come straight off the A register; data phase off D
  assign htrans = a_p0.valid ? NONSEQ : IDLE;
  assign haddr  = ADDR_W'(a_p0.addr);
  assign hwrite = a_p0.write;
  assign hsize  = a_p0.size;
  assign hwdata = DATA_W'(d_p1.wdata);

  // D keeps address/size only so the whole transfer travels as one record
  assign unused_d_fields = ^{d_p1.addr, d_p1.size};

  always_comb begin
    state_n     = state_q;
    a_p0_n      = a_p0;
    d_p1_n      = d_p1;
    hold_n      = hold_q;
    cancel_n    = cancel_q;
    rsp_valid_n = 1'b0;
    rsp_write_n = 1'b0;
    rsp_err_n   = OKAY;
    rsp_rdata_n = '0;
    cmd_x       = '{write: cmd_write, addr: XFER_ADDR_W'(cmd_addr), size: cmd_size,
                    wdata: XFER_DATA_W'(cmd_wdata), valid: 1'b1};

    unique case (state_q)
      RUN: begin
        if (hready) begin
          d_p1_n = a_p0;
          if (!(a_p0.valid && a_p0.write)) d_p1_n.wdata = '0;
          if (accept) a_p0_n = cmd_x;
          else        a_p0_n.valid = 1'b0;
          if (d_p1.valid) begin
            rsp_valid_n = 1'b1;
            rsp_write_n = d_p1.write;
            rsp_rdata_n = d_p1.write ? '0 : hrdata;
          end
        end else if (hresp == ERROR) begin
          // First ERROR cycle: park the pending address phase and go idle
          hold_n       = a_p0;
          a_p0_n.valid = 1'b0;
          cancel_n     = a_p0.valid;
          state_n      = ERR2;
        end
      end
      ERR2: begin
        if (hready) begin
          rsp_valid_n  = 1'b1;
          rsp_write_n  = d_p1.write;
          rsp_err_n    = ERROR;
          d_p1_n.valid = 1'b0;
          cancel_n     = 1'b0;
          state_n      = cancel_q ? REISSUE : RUN;
        end
      end
      REISSUE: begin
        a_p0_n  = hold_q;
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase

    hsel_n = a_p0_n.valid || d_p1_n.valid;
  end

  // Stage boundary: A (_p0) address phase -> D (_p1) data phase -> response
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q   <= RUN;
      a_p0      <= '0;
      d_p1      <= '0;
      hold_q    <= '0;
      cancel_q  <= 1'b0;
      hsel_x    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_n;
      a_p0      <= a_p0_n;
      d_p1      <= d_p1_n;
      hold_q    <= hold_n;
      cancel_q  <= cancel_n;
      hsel_x    <= hsel_n;
      rsp_valid <= rsp_valid_n;
      rsp_write <= rsp_write_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: per-cycle vector table for the normal
// pipeline, hand sequences for ERROR handling and mid-transfer reset.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  logic              hclk = 1'b0;
  logic              hreset_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_write, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              hsel_x, hwrite, hready, hresp;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata, hrdata;

  always #5 hclk = ~hclk;

  ahb_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel_x(hsel_x), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  // Inputs applied during a cycle, and outputs visible during that same cycle
  typedef struct {
    int cv, cw, ca, cs, cd, rdy, resp, rd;
    int e_rdy, e_trans, e_addr, e_write, e_size, e_wdata, e_sel;
    int e_rv, e_rw, e_err, e_rdata;
  } vec_t;

  vec_t vec[18];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rst_n_v = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int cv, input int cw, input int ca, input int cs,
                       input int cd, input int rdy, input int resp, input int rd);
    @(negedge hclk);
    hreset_n  = (rst_n_v != 0);
    cmd_valid = (cv != 0);
    cmd_write = (cw != 0);
    cmd_addr  = ca[ADDR_W-1:0];
    cmd_size  = cs[2:0];
    cmd_wdata = cd[DATA_W-1:0];
    hready    = (rdy != 0);
    hresp     = (resp != 0);
    hrdata    = rd[DATA_W-1:0];
    #1;
  endtask

  task automatic check_row(input int i, input vec_t v);
    chk($sformatf("r%0d cmd_ready", i), int'(cmd_ready), v.e_rdy);
    chk($sformatf("r%0d htrans", i),    int'(htrans),    v.e_trans);
    chk($sformatf("r%0d haddr", i),     int'(haddr),     v.e_addr);
    chk($sformatf("r%0d hwrite", i),    int'(hwrite),    v.e_write);
    chk($sformatf("r%0d hsize", i),     int'(hsize),     v.e_size);
    chk($sformatf("r%0d hwdata", i),    int'(hwdata),    v.e_wdata);
    chk($sformatf("r%0d hsel_x", i),    int'(hsel_x),    v.e_sel);
    chk($sformatf("r%0d rsp_valid", i), int'(rsp_valid), v.e_rv);
    chk($sformatf("r%0d rsp_write", i), int'(rsp_write), v.e_rw);
    chk($sformatf("r%0d rsp_err", i),   int'(rsp_err),   v.e_err);
    chk($sformatf("r%0d rsp_rdata", i), int'(rsp_rdata), v.e_rdata);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           cv cw ca                 cs cd     rdy rsp rd     | rdy tr addr wr sz wdata  sel | rv rw er rdata
    // single write
    vec[0]  = '{1, 1, DATA_SIZE_ADDRESS, 0, 12,    1, 0, 0,      1, 0, 0, 0, 0, 0,     0,  0, 0, 0, 0};
    vec[1]  = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 2, 4, 1, 0, 0,     1,  0, 0, 0, 0};
    vec[2]  = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 4, 1, 0, 12,    1,  0, 0, 0, 0};
    vec[3]  = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 4, 1, 0, 0,     0,  1, 1, 0, 0};
    // back-to-back write then read of the payload register, then idle gap
    vec[4]  = '{1, 1, PAYLOAD_ADDRESS,   1, 'h29,  1, 0, 0,      1, 0, 4, 1, 0, 0,     0,  0, 0, 0, 0};
    vec[5]  = '{1, 0, PAYLOAD_ADDRESS,   1, 0,     1, 0, 0,      1, 2, 2, 1, 1, 0,     1,  0, 0, 0, 0};
    vec[6]  = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 2, 2, 0, 1, 'h29,  1,  0, 0, 0, 0};
    vec[7]  = '{0, 0, 0,                 0, 0,     1, 0, 'h29,   1, 0, 2, 0, 1, 0,     1,  1, 1, 0, 0};
    vec[8]  = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 2, 0, 1, 0,     0,  1, 0, 0, 'h29};
    // two wait states during a write data phase with a read in the address phase
    vec[9]  = '{1, 1, 3,                 0, 'hA5,  1, 0, 0,      1, 0, 2, 0, 1, 0,     0,  0, 0, 0, 0};
    vec[10] = '{1, 0, 5,                 2, 0,     1, 0, 0,      1, 2, 3, 1, 0, 0,     1,  0, 0, 0, 0};
    vec[11] = '{1, 1, 6,                 0, 'h11,  0, 0, 0,      0, 2, 5, 0, 2, 'hA5,  1,  0, 0, 0, 0};
    vec[12] = '{1, 1, 6,                 0, 'h11,  0, 0, 0,      0, 2, 5, 0, 2, 'hA5,  1,  0, 0, 0, 0};
    vec[13] = '{1, 1, 6,                 0, 'h11,  1, 0, 0,      1, 2, 5, 0, 2, 'hA5,  1,  0, 0, 0, 0};
    vec[14] = '{0, 0, 0,                 0, 0,     1, 0, 'h5A,   1, 2, 6, 1, 0, 0,     1,  1, 1, 0, 0};
    vec[15] = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 6, 1, 0, 'h11,  1,  1, 0, 0, 'h5A};
    vec[16] = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 6, 1, 0, 0,     0,  1, 1, 0, 0};
    vec[17] = '{0, 0, 0,                 0, 0,     1, 0, 0,      1, 0, 6, 1, 0, 0,     0,  0, 0, 0, 0};

    rst_n_v = 0;
    repeat (3) drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("reset htrans", int'(htrans), 0);
    chk("reset hsel_x", int'(hsel_x), 0);
    chk("reset hwdata", int'(hwdata), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset cmd_ready", int'(cmd_ready), 0);
    rst_n_v = 1;

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].cv, vec[i].cw, vec[i].ca, vec[i].cs, vec[i].cd,
            vec[i].rdy, vec[i].resp, vec[i].rd);
      check_row(i, vec[i]);
    end

    // ERROR on a write data phase while a read is pending in the address phase
    drive(1, 1, 7, 0, 'h3C, 1, 0, 0);
    drive(1, 0, ERR_STATUS_ADDRESS, 0, 0, 1, 0, 0);
    chk("e1 htrans", int'(htrans), 2);
    chk("e1 haddr", int'(haddr), 7);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("e2 cmd_ready", int'(cmd_ready), 0);
    chk("e2 htrans", int'(htrans), 2);
    chk("e2 haddr", int'(haddr), 1);
    chk("e2 hwdata", int'(hwdata), 'h3C);
    drive(1, 1, 4, 0, 'h77, 1, 1, 0);
    chk("e3 cmd_ready", int'(cmd_ready), 0);
    chk("e3 htrans", int'(htrans), 0);
    chk("e3 hsel_x", int'(hsel_x), 1);
    chk("e3 rsp_valid", int'(rsp_valid), 0);
    drive(1, 1, 4, 0, 'h77, 1, 0, 0);
    chk("e4 cmd_ready", int'(cmd_ready), 0);
    chk("e4 htrans", int'(htrans), 0);
    chk("e4 rsp_valid", int'(rsp_valid), 1);
    chk("e4 rsp_err", int'(rsp_err), 1);
    chk("e4 rsp_write", int'(rsp_write), 1);
    chk("e4 rsp_rdata", int'(rsp_rdata), 0);
    drive(1, 1, 4, 0, 'h77, 1, 0, 0);
    chk("e5 cmd_ready", int'(cmd_ready), 1);
    chk("e5 htrans", int'(htrans), 2);
    chk("e5 haddr", int'(haddr), 1);
    chk("e5 hwrite", int'(hwrite), 0);
    chk("e5 rsp_valid", int'(rsp_valid), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 'hC3);
    chk("e6 htrans", int'(htrans), 2);
    chk("e6 haddr", int'(haddr), 4);
    chk("e6 hwrite", int'(hwrite), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("e7 rsp_valid", int'(rsp_valid), 1);
    chk("e7 rsp_err", int'(rsp_err), 0);
    chk("e7 rsp_write", int'(rsp_write), 0);
    chk("e7 rsp_rdata", int'(rsp_rdata), 'hC3);
    chk("e7 hwdata", int'(hwdata), 'h77);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("e8 rsp_valid", int'(rsp_valid), 1);
    chk("e8 rsp_write", int'(rsp_write), 1);
    chk("e8 rsp_err", int'(rsp_err), 0);
    chk("e8 hsel_x", int'(hsel_x), 0);

    // ERROR with nothing in the address phase: no reissue afterwards
    drive(1, 1, 5, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("f1 htrans", int'(htrans), 2);
    chk("f1 haddr", int'(haddr), 5);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("f2 cmd_ready", int'(cmd_ready), 0);
    chk("f2 hwdata", int'(hwdata), 1);
    chk("f2 htrans", int'(htrans), 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    chk("f3 cmd_ready", int'(cmd_ready), 0);
    chk("f3 rsp_valid", int'(rsp_valid), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("f4 cmd_ready", int'(cmd_ready), 1);
    chk("f4 rsp_valid", int'(rsp_valid), 1);
    chk("f4 rsp_err", int'(rsp_err), 1);
    chk("f4 hsel_x", int'(hsel_x), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("f5 htrans", int'(htrans), 0);
    chk("f5 rsp_valid", int'(rsp_valid), 0);

    // Reset during a data phase drops the transfer silently
    drive(1, 1, 3, 0, 'h44, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g1 htrans", int'(htrans), 2);
    rst_n_v = 0;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g2 hwdata", int'(hwdata), 'h44);
    chk("g2 hsel_x", int'(hsel_x), 1);
    chk("g2 cmd_ready", int'(cmd_ready), 0);
    rst_n_v = 1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g3 htrans", int'(htrans), 0);
    chk("g3 haddr", int'(haddr), 0);
    chk("g3 hwrite", int'(hwrite), 0);
    chk("g3 hsize", int'(hsize), 0);
    chk("g3 hwdata", int'(hwdata), 0);
    chk("g3 hsel_x", int'(hsel_x), 0);
    chk("g3 rsp_valid", int'(rsp_valid), 0);
    chk("g3 cmd_ready", int'(cmd_ready), 1);
    drive(1, 1, PAYLOAD_ADDRESS, 0, 'h5E, 1, 0, 0);
    chk("g4 rsp_valid", int'(rsp_valid), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g5 htrans", int'(htrans), 2);
    chk("g5 haddr", int'(haddr), 2);
    chk("g5 hwrite", int'(hwrite), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g6 hwdata", int'(hwdata), 'h5E);
    chk("g6 hsel_x", int'(hsel_x), 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    chk("g7 rsp_valid", int'(rsp_valid), 1);
    chk("g7 rsp_write", int'(rsp_write), 1);
    chk("g7 rsp_err", int'(rsp_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
